cruce_controller: RTL and testbench
===================================

// Module: cruce_controller
// PURPOSE
//  Sequences two traffic-light instances (direction A, direction B) sharing one crossing.
//  Emits single-cycle CHANGE pulses and the shared CHRONO ms count.
//  Watches each light's GREEN/YELLOW/RED outputs and enforces mutual exclusion.
//  Forces a safe all-red FAULT on any conflict.
// PARAMETERS
//  CLK_PER_MS    50000  CLK cycles per CHRONO increment (>=2)
//  ALLRED_MS     1000   all-red clearance before opening either direction
//  MIN_GREEN_MS  5000   green time guaranteed before yielding to a pending request
//  MAX_GREEN_MS  20000  green time after which direction yields unconditionally (<=65535)
//  TIMEOUT_MS    6000   max wait for a light to reach commanded colour
// PORTS
//  CLK       in   1   system clock, all logic on posedge
//  RST       in   1   asynchronous, active-high reset
//  EN        in   1   crossing enable; low = lights off
//  REQ_A     in   1   async request for A (button/loop), synchronised internally
//  REQ_B     in   1   async request for B
//  A_GRY     in   3   light A status {GREEN,YELLOW,RED}
//  B_GRY     in   3   light B status {GREEN,YELLOW,RED}
//  CHANGE_A  out  1   1-cycle change command to light A
//  CHANGE_B  out  1   1-cycle change command to light B
//  LIGHT_EN  out  1   EN to both lights
//  LIGHT_RST out  1   RST to both lights (forces red)
//  CHRONO    out  32  free-running ms count, wraps 2^32-1 -> 0
//  PHASE     out  3   current FSM state encoding
//  FAULT     out  1   sticky fault flag
// BEHAVIOUR
//  Reset values: CHANGE_*=0, LIGHT_EN=0, LIGHT_RST=1, CHRONO=0, FAULT=0, PHASE=INIT, next_dir=A.
//  Prescaler and tick:
//   - prescaler counts 0..CLK_PER_MS-1; ms_tick is 1 cycle at wrap.
//   - CHRONO += 1 on ms_tick; runs regardless of EN and FAULT.
//  phase_ms: 16-bit, cleared on every state entry, +1 per ms_tick, saturates at 65535.
//  Requests:
//   - 2-FF synchroniser, then rising-edge detect into pend_A / pend_B.
//   - pend_X is cleared on the cycle X_GO is entered.
//   - Set and clear in the same cycle: clear wins.
//  FSM transitions:
//   - INIT: LIGHT_RST=1, LIGHT_EN=EN; one cycle, then ALL_RED.
//   - ALL_RED: needs both GRY==001 and phase_ms>=ALLRED_MS.
//     Then pulses CHANGE_<next_dir> and goes to <next_dir>_OPEN.
//   - X_OPEN: waits X_GRY==100, then X_GO. phase_ms>=TIMEOUT_MS -> FAULT.
//   - X_GO leaves when (pend_other && phase_ms>=MIN_GREEN_MS) or phase_ms>=MAX_GREEN_MS.
//     On leaving: pulses CHANGE_X, goes to X_CLOSE.
//   - X_CLOSE: waits X_GRY==001, then sets next_dir=other and goes to ALL_RED.
//     Timeout -> FAULT.
//  CHANGE rules:
//   - Exactly one cycle high, only on the transition cycle.
//   - Never asserted while the target light shows yellow.
//  Conflict monitor, any state except INIT/FAULT:
//   - Both lights non-red in the same cycle -> FAULT next cycle.
//   - X_GRY not in {001,010,100} -> FAULT.
//   - In X_GO, X_GRY!=100 -> FAULT.
//  FAULT: FAULT=1, LIGHT_RST=1, CHANGE_*=0; exits only via RST.
//  EN low: LIGHT_EN=0, FSM forced to INIT, pend_* cleared, FAULT held.
//   - On EN rising, restart from INIT.
//  Async RST mid-phase: immediate return to reset values; CHRONO restarts at 0.
// CONFIGURATION
//  CRUCE_FAULT_FLASH_EN:
//   - Defined: in FAULT, LIGHT_RST=1 and LIGHT_EN toggles every 500 ms of CHRONO (flashing red).
//   - Undefined: LIGHT_EN=1 in FAULT (steady red).
// STRUCTURE
//  semaforo_pkg holds shared definitions:
//   - colour codes RED=3'b001, YELLOW=3'b010, GREEN=3'b100, OFF=3'b000
//   - PHASE encodings: INIT, ALL_RED, A_OPEN, A_GO, A_CLOSE, B_OPEN, B_GO, B_CLOSE, FAULT
//  Sub-module ms_tick_gen: prescaler, ms_tick and CHRONO. FSM, request latches and monitor stay in this module.
// TESTING (bench params: CLK_PER_MS=4, ALLRED_MS=2, MIN_GREEN_MS=5, MAX_GREEN_MS=10, TIMEOUT_MS=8)
//  1 Reset, EN=1, behavioural light model with yellow of 3 ms:
//    INIT -> ALL_RED; CHANGE_A at ms 2; A_GO at ms 5.
//  2 No requests: A green exactly 10 ms, then CHANGE_A.
//    After A red + 2 ms all-red, CHANGE_B.
//  3 REQ_B pulse at A_GO ms 1: A yields at ms 5.
//    REQ_B pulse at ms 7: A yields at ms 7.
//  4 Model forces B_GRY=010 during A_GO:
//    FAULT=1 and LIGHT_RST=1 next cycle; RST clears.
//  5 Model never reaches green: FAULT after 8 ms in A_OPEN.
//    With CRUCE_FAULT_FLASH_EN, LIGHT_EN toggles every 500 ms.
//  6 EN low mid B_GO: LIGHT_EN=0, PHASE=INIT, CHRONO keeps counting.
//    EN high restarts at ALL_RED, next_dir unchanged.

Source files
------------

// File: rtl/semaforo_pkg.sv
// semaforo_pkg: shared definitions for the crossing controller.
//   - Light colour codes as reported on a light's {GREEN,YELLOW,RED} status bus.
//   - Controller state encoding and the 3-bit PHASE code reported for each state.
//   - Direction selector used to alternate which approach opens next.
package semaforo_pkg;

  localparam logic [2:0] OFF    = 3'b000;
  localparam logic [2:0] RED    = 3'b001;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b100;

  // The eight operational states map one-to-one onto PHASE. The fault state
  // has no code of its own in the 3-bit PHASE field; it reports the INIT code
  // because the lights are held in reset exactly as in INIT, and the sticky
  // FAULT output distinguishes the two.
  typedef enum logic [3:0] {
    ST_INIT    = 4'd0,
    ST_ALL_RED = 4'd1,
    ST_A_OPEN  = 4'd2,
    ST_A_GO    = 4'd3,
    ST_A_CLOSE = 4'd4,
    ST_B_OPEN  = 4'd5,
    ST_B_GO    = 4'd6,
    ST_B_CLOSE = 4'd7,
    ST_FAULT   = 4'd8
  } state_e;

  typedef enum logic {
    DIR_A = 1'b0,
    DIR_B = 1'b1
  } dir_e;

  function automatic logic [2:0] phase_code(input state_e s);
    if (s == ST_FAULT) return 3'd0;
    return s[2:0];
  endfunction

  // Only the three single-lamp codes are legal light states.
  function automatic logic gry_valid(input logic [2:0] g);
    return (g == RED) || (g == YELLOW) || (g == GREEN);
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// ms_tick_gen: millisecond time base for the crossing controller.
//   Parameter CLK_PER_MS : CLK cycles per millisecond (>= 2).
//   CLK     in   clock, all logic on posedge
//   RST     in   asynchronous active-high reset
//   ms_tick out  one-cycle strobe on the cycle the prescaler wraps
//   CHRONO  out  free-running millisecond count, wraps 2^32-1 -> 0
module ms_tick_gen #(
  parameter int CLK_PER_MS = 50000
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        ms_tick,
  output logic [31:0] CHRONO
);

  localparam int PW = (CLK_PER_MS > 2) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_MS - 1);

  logic [PW-1:0] presc;

  // Strobe is decoded from the prescaler so CHRONO and every consumer of the
  // strobe update on the same edge as the prescaler wrap.
  assign ms_tick = (presc == PRESC_LAST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      presc  <= '0;
      CHRONO <= '0;
    end else begin
      presc  <= ms_tick ? '0 : presc + PW'(1);
      if (ms_tick) CHRONO <= CHRONO + 32'd1;
    end
  end

endmodule

// File: rtl/cruce_controller.sv
// cruce_controller: sequences two traffic lights (A and B) that share one
// crossing, keeps them mutually exclusive and forces a safe all-red fault on
// any conflict.
//   Parameters: CLK_PER_MS, ALLRED_MS, MIN_GREEN_MS, MAX_GREEN_MS (<= 65535),
//   TIMEOUT_MS.
//   CLK        in   system clock
//   RST        in   asynchronous active-high reset
//   EN         in   crossing enable; low turns the lights off
//   REQ_A/B    in   asynchronous requests (button / loop), synchronised here
//   A_GRY/B_GRY in  light status {GREEN,YELLOW,RED}
//   CHANGE_A/B out  one-cycle change command to each light
//   LIGHT_EN   out  enable to both lights
//   LIGHT_RST  out  reset to both lights (forces red)
//   CHRONO     out  free-running millisecond count
//   PHASE      out  current state code
//   FAULT      out  sticky fault flag, cleared only by RST
// Build option: define CRUCE_FAULT_FLASH_EN to flash the red lamps in fault
// (LIGHT_EN toggles every 500 ms); otherwise the fault shows steady red.
module cruce_controller
  import semaforo_pkg::*;
#(
  parameter int CLK_PER_MS   = 50000,
  parameter int ALLRED_MS    = 1000,
  parameter int MIN_GREEN_MS = 5000,
  parameter int MAX_GREEN_MS = 20000,
  parameter int TIMEOUT_MS   = 6000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        EN,
  input  logic        REQ_A,
  input  logic        REQ_B,
  input  logic [2:0]  A_GRY,
  input  logic [2:0]  B_GRY,
  output logic        CHANGE_A,
  output logic        CHANGE_B,
  output logic        LIGHT_EN,
  output logic        LIGHT_RST,
  output logic [31:0] CHRONO,
  output logic [2:0]  PHASE,
  output logic        FAULT
);

  localparam logic [15:0] ALLRED_LIM  = 16'(ALLRED_MS);
  localparam logic [15:0] MIN_GRN_LIM = 16'(MIN_GREEN_MS);
  localparam logic [15:0] MAX_GRN_LIM = 16'(MAX_GREEN_MS);
  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_MS);

  logic        ms_tick;
  state_e      state;
  dir_e        next_dir;
  logic [15:0] phase_ms;
  logic        pend_a;
  logic        pend_b;
  logic        conflict;

  ms_tick_gen #(
    .CLK_PER_MS (CLK_PER_MS)
  ) u_tick (
    .CLK     (CLK),
    .RST     (RST),
    .ms_tick (ms_tick),
    .CHRONO  (CHRONO)
  );

  // Request synchronisers: _p0/_p1 resolve metastability, _p2 holds the
  // previous synchronised level for rising-edge detection.
  logic req_a_p0, req_a_p1, req_a_p2;
  logic req_b_p0, req_b_p1, req_b_p2;
  logic rise_a, rise_b;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      req_a_p0 <= 1'b0;
      req_a_p1 <= 1'b0;
      req_a_p2 <= 1'b0;
      req_b_p0 <= 1'b0;
      req_b_p1 <= 1'b0;
      req_b_p2 <= 1'b0;
    end else begin
      req_a_p0 <= REQ_A;
      req_a_p1 <= req_a_p0;
      req_a_p2 <= req_a_p1;
      req_b_p0 <= REQ_B;
      req_b_p1 <= req_b_p0;
      req_b_p2 <= req_b_p1;
    end
  end

  assign rise_a = req_a_p1 & ~req_a_p2;
  assign rise_b = req_b_p1 & ~req_b_p2;

  // Conflict monitor: two lit approaches at once, an illegal status code, or
  // the open direction dropping out of green while it owns the crossing.
  always_comb begin
    conflict = 1'b0;
    if ((A_GRY != RED) && (B_GRY != RED)) conflict = 1'b1;
    if (!gry_valid(A_GRY) || !gry_valid(B_GRY)) conflict = 1'b1;
    if ((state == ST_A_GO) && (A_GRY != GREEN)) conflict = 1'b1;
    if ((state == ST_B_GO) && (B_GRY != GREEN)) conflict = 1'b1;
  end

  assign PHASE = phase_code(state);

`ifdef CRUCE_FAULT_FLASH_EN
  logic [8:0] flash_ms;
`endif

  // Controller FSM. Every transition clears phase_ms; the later assignment in
  // a transition branch overrides the default per-tick increment.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_INIT;
      next_dir  <= DIR_A;
      phase_ms  <= '0;
      pend_a    <= 1'b0;
      pend_b    <= 1'b0;
      CHANGE_A  <= 1'b0;
      CHANGE_B  <= 1'b0;
      LIGHT_EN  <= 1'b0;
      LIGHT_RST <= 1'b1;
      FAULT     <= 1'b0;
`ifdef CRUCE_FAULT_FLASH_EN
      flash_ms  <= '0;
`endif
    end else begin
      CHANGE_A <= 1'b0;
      CHANGE_B <= 1'b0;
      if (ms_tick && (phase_ms != 16'hFFFF)) phase_ms <= phase_ms + 16'd1;
      if (rise_a) pend_a <= 1'b1;
      if (rise_b) pend_b <= 1'b1;

      if (state == ST_FAULT) begin
        // Sticky: only RST leaves this state. EN still gates the lamps.
        FAULT     <= 1'b1;
        LIGHT_RST <= 1'b1;
        if (!EN) begin
          LIGHT_EN <= 1'b0;
          pend_a   <= 1'b0;
          pend_b   <= 1'b0;
        end else begin
`ifdef CRUCE_FAULT_FLASH_EN
          if (ms_tick) begin
            if (flash_ms == 9'd499) begin
              flash_ms <= '0;
              LIGHT_EN <= ~LIGHT_EN;
            end else begin
              flash_ms <= flash_ms + 9'd1;
            end
          end
`else
          LIGHT_EN <= 1'b1;
`endif
        end
      end else if (!EN) begin
        state     <= ST_INIT;
        LIGHT_EN  <= 1'b0;
        LIGHT_RST <= 1'b1;
        pend_a    <= 1'b0;
        pend_b    <= 1'b0;
        if (state != ST_INIT) phase_ms <= '0;
      end else if ((state != ST_INIT) && conflict) begin
        state     <= ST_FAULT;
        phase_ms  <= '0;
        FAULT     <= 1'b1;
        LIGHT_RST <= 1'b1;
        LIGHT_EN  <= 1'b1;
`ifdef CRUCE_FAULT_FLASH_EN
        flash_ms  <= '0;
`endif
      end else begin
        case (state)
          ST_INIT: begin
            LIGHT_RST <= 1'b0;
            LIGHT_EN  <= EN;
            state     <= ST_ALL_RED;
            phase_ms  <= '0;
          end
          ST_ALL_RED: begin
            if ((A_GRY == RED) && (B_GRY == RED) && (phase_ms >= ALLRED_LIM)) begin
              phase_ms <= '0;
              if (next_dir == DIR_A) begin
                CHANGE_A <= 1'b1;
                state    <= ST_A_OPEN;
              end else begin
                CHANGE_B <= 1'b1;
                state    <= ST_B_OPEN;
              end
            end
          end
          ST_A_OPEN: begin
            if (A_GRY == GREEN) begin
              state    <= ST_A_GO;
              phase_ms <= '0;
              pend_a   <= 1'b0;
            end else if (phase_ms >= TIMEOUT_LIM) begin
              state     <= ST_FAULT;
              phase_ms  <= '0;
              FAULT     <= 1'b1;
              LIGHT_RST <= 1'b1;
`ifdef CRUCE_FAULT_FLASH_EN
              flash_ms  <= '0;
`endif
            end
          end
          ST_A_GO: begin
            if ((pend_b && (phase_ms >= MIN_GRN_LIM)) || (phase_ms >= MAX_GRN_LIM)) begin
              CHANGE_A <= 1'b1;
              state    <= ST_A_CLOSE;
              phase_ms <= '0;
            end
          end
          ST_A_CLOSE: begin
            if (A_GRY == RED) begin
              next_dir <= DIR_B;
              state    <= ST_ALL_RED;
              phase_ms <= '0;
            end else if (phase_ms >= TIMEOUT_LIM) begin
              state     <= ST_FAULT;
              phase_ms  <= '0;
              FAULT     <= 1'b1;
              LIGHT_RST <= 1'b1;
`ifdef CRUCE_FAULT_FLASH_EN
              flash_ms  <= '0;
`endif
            end
          end
          ST_B_OPEN: begin
            if (B_GRY == GREEN) begin
              state    <= ST_B_GO;
              phase_ms <= '0;
              pend_b   <= 1'b0;
            end else if (phase_ms >= TIMEOUT_LIM) begin
              state     <= ST_FAULT;
              phase_ms  <= '0;
              FAULT     <= 1'b1;
              LIGHT_RST <= 1'b1;
`ifdef CRUCE_FAULT_FLASH_EN
              flash_ms  <= '0;
`endif
            end
          end
          ST_B_GO: begin
            if ((pend_a && (phase_ms >= MIN_GRN_LIM)) || (phase_ms >= MAX_GRN_LIM)) begin
              CHANGE_B <= 1'b1;
              state    <= ST_B_CLOSE;
              phase_ms <= '0;
            end
          end
          ST_B_CLOSE: begin
            if (B_GRY == RED) begin
              next_dir <= DIR_A;
              state    <= ST_ALL_RED;
              phase_ms <= '0;
            end else if (phase_ms >= TIMEOUT_LIM) begin
              state     <= ST_FAULT;
              phase_ms  <= '0;
              FAULT     <= 1'b1;
              LIGHT_RST <= 1'b1;
`ifdef CRUCE_FAULT_FLASH_EN
              flash_ms  <= '0;
`endif
            end
          end
          default: begin
            state    <= ST_FAULT;
            phase_ms <= '0;
            FAULT    <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cruce_controller.sv
// tb_cruce_controller: directed bench for cruce_controller with small timing
// parameters and a behavioural light model (3 ms yellow between red and green).
module tb_cruce_controller;

  localparam int CPM = 4;
  localparam int YEL_CYC = 3 * CPM;

  localparam logic [2:0] C_RED = 3'b001;
  localparam logic [2:0] C_YEL = 3'b010;
  localparam logic [2:0] C_GRN = 3'b100;

  localparam logic [31:0] P_INIT    = 32'd0;
  localparam logic [31:0] P_ALL_RED = 32'd1;
  localparam logic [31:0] P_A_OPEN  = 32'd2;
  localparam logic [31:0] P_A_GO    = 32'd3;
  localparam logic [31:0] P_A_CLOSE = 32'd4;
  localparam logic [31:0] P_B_OPEN  = 32'd5;
  localparam logic [31:0] P_B_GO    = 32'd6;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        EN = 1'b1;
  logic        REQ_A = 1'b0;
  logic        REQ_B = 1'b0;
  logic [2:0]  A_GRY;
  logic [2:0]  B_GRY;
  logic        CHANGE_A, CHANGE_B, LIGHT_EN, LIGHT_RST, FAULT;
  logic [31:0] CHRONO;
  logic [2:0]  PHASE;

  int n_asrt = 0;
  int n_fail = 0;
  int edge_n = 0;

  // Light model state and fault-injection knobs.
  logic [2:0] a_mod = C_RED, b_mod = C_RED;
  logic [2:0] a_tgt = C_GRN, b_tgt = C_GRN;
  int         a_cnt = 0, b_cnt = 0;
  logic       a_stuck = 1'b0;
  logic       b_force = 1'b0;

  assign A_GRY = a_mod;
  assign B_GRY = b_force ? C_YEL : b_mod;

  always #5 CLK = ~CLK;

  cruce_controller #(
    .CLK_PER_MS   (CPM),
    .ALLRED_MS    (2),
    .MIN_GREEN_MS (5),
    .MAX_GREEN_MS (10),
    .TIMEOUT_MS   (8)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .EN        (EN),
    .REQ_A     (REQ_A),
    .REQ_B     (REQ_B),
    .A_GRY     (A_GRY),
    .B_GRY     (B_GRY),
    .CHANGE_A  (CHANGE_A),
    .CHANGE_B  (CHANGE_B),
    .LIGHT_EN  (LIGHT_EN),
    .LIGHT_RST (LIGHT_RST),
    .CHRONO    (CHRONO),
    .PHASE     (PHASE),
    .FAULT     (FAULT)
  );

  // Behavioural lights: CHANGE from red goes yellow then green, from green
  // goes yellow then red; LIGHT_RST forces red at once.
  always @(posedge CLK) begin
    if (LIGHT_RST) begin
      a_mod <= C_RED;
      a_cnt <= 0;
    end else if (a_mod == C_YEL) begin
      if (a_cnt == 0) a_mod <= a_tgt;
      else a_cnt <= a_cnt - 1;
    end else if (CHANGE_A && !a_stuck) begin
      a_tgt <= (a_mod == C_RED) ? C_GRN : C_RED;
      a_mod <= C_YEL;
      a_cnt <= YEL_CYC - 1;
    end
  end

  always @(posedge CLK) begin
    if (LIGHT_RST) begin
      b_mod <= C_RED;
      b_cnt <= 0;
    end else if (b_mod == C_YEL) begin
      if (b_cnt == 0) b_mod <= b_tgt;
      else b_cnt <= b_cnt - 1;
    end else if (CHANGE_B) begin
      b_tgt <= (b_mod == C_RED) ? C_GRN : C_RED;
      b_mod <= C_YEL;
      b_cnt <= YEL_CYC - 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s at edge %0d: observed=%0d expected=%0d", tag, edge_n, obs, exp);
    end
  endtask

  // Advance to 1 time unit after posedge number e (counted from reset release).
  task automatic goto(input int e);
    while (edge_n < e) begin
      @(posedge CLK);
      edge_n++;
    end
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    a_stuck = 1'b0;
    b_force = 1'b0;
    REQ_A = 1'b0;
    REQ_B = 1'b0;
    EN = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    edge_n = 0;
  endtask

  initial begin
    // ---- 1: reset values, then first opening of A ----
    @(negedge CLK);
    chk("rst_change_a", 32'(CHANGE_A), 32'd0);
    chk("rst_change_b", 32'(CHANGE_B), 32'd0);
    chk("rst_light_en", 32'(LIGHT_EN), 32'd0);
    chk("rst_light_rst", 32'(LIGHT_RST), 32'd1);
    chk("rst_chrono", CHRONO, 32'd0);
    chk("rst_fault", 32'(FAULT), 32'd0);
    chk("rst_phase", 32'(PHASE), P_INIT);
    do_reset();
    goto(1);
    chk("t1_allred_entry", 32'(PHASE), P_ALL_RED);
    chk("t1_light_rst_off", 32'(LIGHT_RST), 32'd0);
    chk("t1_light_en_on", 32'(LIGHT_EN), 32'd1);
    goto(8);
    chk("t1_no_early_change", 32'(CHANGE_A), 32'd0);
    goto(9);
    chk("t1_change_a", 32'(CHANGE_A), 32'd1);
    chk("t1_a_open", 32'(PHASE), P_A_OPEN);
    chk("t1_change_ms", CHRONO, 32'd2);
    goto(10);
    chk("t1_change_one_cycle", 32'(CHANGE_A), 32'd0);
    goto(22);
    chk("t1_still_open", 32'(PHASE), P_A_OPEN);
    goto(23);
    chk("t1_a_go", 32'(PHASE), P_A_GO);
    chk("t1_a_go_ms", CHRONO, 32'd5);

    // ---- 2: no requests, A green for MAX_GREEN then hand over to B ----
    goto(60);
    chk("t2_a_go_held", 32'(PHASE), P_A_GO);
    chk("t2_ms15", CHRONO, 32'd15);
    goto(61);
    chk("t2_change_a_max", 32'(CHANGE_A), 32'd1);
    chk("t2_a_close", 32'(PHASE), P_A_CLOSE);
    goto(74);
    chk("t2_wait_red", 32'(PHASE), P_A_CLOSE);
    goto(75);
    chk("t2_allred", 32'(PHASE), P_ALL_RED);
    goto(80);
    chk("t2_no_early_b", 32'(CHANGE_B), 32'd0);
    goto(81);
    chk("t2_change_b", 32'(CHANGE_B), 32'd1);
    chk("t2_no_change_a", 32'(CHANGE_A), 32'd0);
    chk("t2_b_open", 32'(PHASE), P_B_OPEN);
    goto(95);
    chk("t2_b_go", 32'(PHASE), P_B_GO);

    // ---- 6: EN low mid B_GO, then restart keeping next_dir=B ----
    goto(100);
    EN = 1'b0;
    goto(101);
    chk("t6_phase_init", 32'(PHASE), P_INIT);
    chk("t6_light_en_off", 32'(LIGHT_EN), 32'd0);
    chk("t6_chrono_25", CHRONO, 32'd25);
    goto(104);
    chk("t6_chrono_runs", CHRONO, 32'd26);
    chk("t6_held_init", 32'(PHASE), P_INIT);
    EN = 1'b1;
    goto(105);
    chk("t6_restart_allred", 32'(PHASE), P_ALL_RED);
    chk("t6_light_en_on", 32'(LIGHT_EN), 32'd1);
    goto(112);
    chk("t6_allred_wait", 32'(PHASE), P_ALL_RED);
    goto(113);
    chk("t6_next_dir_b", 32'(CHANGE_B), 32'd1);
    chk("t6_b_open", 32'(PHASE), P_B_OPEN);

    // ---- 3a: request at A_GO ms 1, A yields at MIN_GREEN ----
    do_reset();
    goto(25);
    REQ_B = 1'b1;
    goto(29);
    REQ_B = 1'b0;
    goto(40);
    chk("t3a_before_min", 32'(PHASE), P_A_GO);
    goto(41);
    chk("t3a_yield_change", 32'(CHANGE_A), 32'd1);
    chk("t3a_yield_close", 32'(PHASE), P_A_CLOSE);

    // ---- 3b: request at A_GO ms 7, A yields at ms 7 ----
    do_reset();
    goto(41);
    chk("t3b_no_req_hold", 32'(PHASE), P_A_GO);
    goto(48);
    REQ_B = 1'b1;
    goto(51);
    chk("t3b_before_yield", 32'(PHASE), P_A_GO);
    REQ_B = 1'b0;
    goto(52);
    chk("t3b_yield_change", 32'(CHANGE_A), 32'd1);
    chk("t3b_yield_close", 32'(PHASE), P_A_CLOSE);

    // ---- 4: B shows yellow during A_GO -> fault, RST clears ----
    do_reset();
    goto(30);
    chk("t4_pre_fault", 32'(FAULT), 32'd0);
    b_force = 1'b1;
    goto(31);
    chk("t4_fault", 32'(FAULT), 32'd1);
    chk("t4_light_rst", 32'(LIGHT_RST), 32'd1);
    chk("t4_fault_phase", 32'(PHASE), P_INIT);
    b_force = 1'b0;
    goto(35);
    chk("t4_sticky", 32'(FAULT), 32'd1);
    chk("t4_no_change", 32'(CHANGE_A), 32'd0);
    RST = 1'b1;
    #1;
    chk("t4_rst_fault", 32'(FAULT), 32'd0);
    chk("t4_rst_chrono", CHRONO, 32'd0);
    chk("t4_rst_light_rst", 32'(LIGHT_RST), 32'd1);

    // ---- 5: A never turns green -> timeout fault ----
    do_reset();
    a_stuck = 1'b1;
    goto(40);
    chk("t5_open_wait", 32'(PHASE), P_A_OPEN);
    chk("t5_no_fault_yet", 32'(FAULT), 32'd0);
    goto(41);
    chk("t5_timeout_fault", 32'(FAULT), 32'd1);
    chk("t5_light_rst", 32'(LIGHT_RST), 32'd1);
    chk("t5_light_en", 32'(LIGHT_EN), 32'd1);
`ifdef CRUCE_FAULT_FLASH_EN
    goto(2039);
    chk("t5_flash_before", 32'(LIGHT_EN), 32'd1);
    goto(2040);
    chk("t5_flash_toggle", 32'(LIGHT_EN), 32'd0);
`else
    goto(60);
    chk("t5_steady_red", 32'(LIGHT_EN), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
